// File: rtl/washer_pkg.sv
// Shared washer controller definitions: motor state encoding and the
// processor opcode map.
package washer_pkg;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_FWD  = 2'd1,
      M_REV  = 2'd2,
      M_DEAD = 2'd3
   } motor_state_e;

   localparam logic [7:0] OP_WAIT    = 8'h01;
   localparam logic [7:0] OP_FILL    = 8'h02;
   localparam logic [7:0] OP_RELEASE = 8'h03;
   localparam logic [7:0] OP_FORWARD = 8'h04;
   localparam logic [7:0] OP_REVERSE = 8'h05;
   localparam logic [7:0] OP_SET     = 8'h11;
   localparam logic [7:0] OP_DEC     = 8'h12;
   localparam logic [7:0] OP_JZ      = 8'h21;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that saturates at zero; shared by the dead-time
// and minimum on-time interlocks.
module hold_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (dec_i && (count_q != '0))
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/actuator_driver.sv
// Washer actuator output stage: motor dead-time, valve interlocks, overflow
// cut-off and sticky fault. Optional min on-time via ACTUATOR_MIN_ON_EN.
module actuator_driver
   import washer_pkg::*;
#(
   parameter int unsigned DEADTIME = 200,
   parameter int unsigned MIN_ON   = 100,
   parameter int unsigned CNT_W    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic ctrl_fill,
   input  logic ctrl_release,
   input  logic ctrl_forward,
   input  logic ctrl_reverse,
   input  logic level_full,
   input  logic fault_clr,
   output logic motor_fwd,
   output logic motor_rev,
   output logic valve_fill,
   output logic valve_drain,
   output logic busy,
   output logic fault
);

   localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEADTIME - 1);
   localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_ON - 1);

   motor_state_e state_q, state_d;
   logic motor_fwd_q, motor_rev_q, valve_fill_q, valve_drain_q, busy_q, fault_q;
   logic fault_d;
   logic req_fill, req_rel, req_fwd, req_rev;
   logic tmr_load, tmr_dec, tmr_zero, exit_req;
   logic [CNT_W-1:0] tmr_val;

   assign req_fill = ctrl_fill    & ena;
   assign req_rel  = ctrl_release & ena;
   assign req_fwd  = ctrl_forward & ena;
   assign req_rev  = ctrl_reverse & ena;

   assign exit_req = (state_q == M_FWD) ? (~req_fwd | req_rev) : (~req_rev | req_fwd);

   // Entry always loads MIN_LD; without min on-time the value is simply never consumed.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = DEAD_LD;
      tmr_dec  = 1'b0;
      unique case (state_q)
         M_IDLE: begin
            if (req_fwd & ~req_rev) begin
               state_d  = M_FWD;
               tmr_load = 1'b1;
               tmr_val  = MIN_LD;
            end else if (req_rev & ~req_fwd) begin
               state_d  = M_REV;
               tmr_load = 1'b1;
               tmr_val  = MIN_LD;
            end
         end
         M_FWD, M_REV: begin
`ifdef ACTUATOR_MIN_ON_EN
            tmr_dec = 1'b1;
            if (~ena | (tmr_zero & exit_req)) begin
`else
            if (exit_req) begin
`endif
               state_d  = M_DEAD;
               tmr_load = 1'b1;
               tmr_val  = DEAD_LD;
            end
         end
         M_DEAD: begin
            if (tmr_zero) state_d = M_IDLE;
            else          tmr_dec = 1'b1;
         end
         default: state_d = M_IDLE;
      endcase
   end

   always_comb begin
      fault_d = fault_q;
      if ((req_fwd & req_rev) | (req_fill & req_rel)) fault_d = 1'b1;
      else if (fault_clr)                              fault_d = 1'b0;
   end

   hold_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= M_IDLE;
         motor_fwd_q   <= 1'b0;
         motor_rev_q   <= 1'b0;
         valve_fill_q  <= 1'b0;
         valve_drain_q <= 1'b0;
         busy_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         motor_fwd_q   <= (state_d == M_FWD);
         motor_rev_q   <= (state_d == M_REV);
         valve_fill_q  <= req_fill & ~req_rel & ~level_full;
         valve_drain_q <= req_rel & ~req_fill;
         busy_q        <= (state_d != M_IDLE);
         fault_q       <= fault_d;
      end
   end

   assign motor_fwd   = motor_fwd_q;
   assign motor_rev   = motor_rev_q;
   assign valve_fill  = valve_fill_q;
   assign valve_drain = valve_drain_q;
   assign busy        = busy_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_actuator_driver.sv
// Scoreboard bench for actuator_driver (DEADTIME=4, MIN_ON=3); model is
// timestamp based and follows ACTUATOR_MIN_ON_EN like the design.
module tb_actuator_driver;

   localparam int DT = 4;
   localparam int MO = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ena = 1'b0, ctrl_fill = 1'b0, ctrl_release = 1'b0;
   logic ctrl_forward = 1'b0, ctrl_reverse = 1'b0, level_full = 1'b0, fault_clr = 1'b0;
   logic motor_fwd, motor_rev, valve_fill, valve_drain, busy, fault;

   always #5 clk = ~clk;

   actuator_driver #(.DEADTIME(DT), .MIN_ON(MO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release),
      .ctrl_forward(ctrl_forward), .ctrl_reverse(ctrl_reverse),
      .level_full(level_full), .fault_clr(fault_clr),
      .motor_fwd(motor_fwd), .motor_rev(motor_rev),
      .valve_fill(valve_fill), .valve_drain(valve_drain),
      .busy(busy), .fault(fault)
   );

   typedef struct packed { logic mf, mr, vf, vd, bz, ft; } obs_t;

   obs_t exp_q[$];
   int total = 0;
   int bad = 0;

   // Reference model: edge index, direction (0 off, 1 fwd, 2 rev) and edge timestamps.
   int k, dir, on_edge, off_edge;
   bit flt;

   function automatic obs_t sample_dut();
      obs_t o;
      o = '{motor_fwd, motor_rev, valve_fill, valve_drain, busy, fault};
      return o;
   endfunction

   task automatic model_reset();
      k = 0; dir = 0; on_edge = -1000; off_edge = -1000; flt = 1'b0;
   endtask

   task automatic model_step();
      bit rf, rr, rfi, rre, cond, ex;
      obs_t e;
      rf = ctrl_forward & ena;  rr = ctrl_reverse & ena;
      rfi = ctrl_fill & ena;    rre = ctrl_release & ena;
      k++;
      if (dir != 0) begin
         cond = (dir == 1) ? (!rf || rr) : (!rr || rf);
`ifdef ACTUATOR_MIN_ON_EN
         ex = !ena || ((k - on_edge >= MO) && cond);
`else
         ex = cond;
`endif
         if (ex) begin dir = 0; off_edge = k; end
      end else if (k - off_edge >= DT + 1) begin
         if (rf && !rr)      begin dir = 1; on_edge = k; end
         else if (rr && !rf) begin dir = 2; on_edge = k; end
      end
      if ((rf && rr) || (rfi && rre)) flt = 1'b1;
      else if (fault_clr)             flt = 1'b0;
      e.mf = (dir == 1);
      e.mr = (dir == 2);
      e.vf = rfi && !rre && !level_full;
      e.vd = rre && !rfi;
      e.bz = (dir != 0) || (k - off_edge < DT);
      e.ft = flt;
      exp_q.push_back(e);
   endtask

   // Stimulus sits at a falling edge; one call covers one rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic check_reset(input string name);
      obs_t got;
      #1;
      got = sample_dut();
      total++;
      if (got !== '0) begin
         bad++;
         $display("FAIL %s got=%b required=%b", name, got, 6'b0);
      end
   endtask

   always @(posedge clk) begin
      obs_t e, got;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = sample_dut();
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL outputs edge=%0d got(mf mr vf vd bz ft)=%b required=%b", k, got, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset("reset_values");
      rst = 1'b0;
      ena = 1'b1;

      // direction change with dead-time gap
      ctrl_forward = 1'b1; step(10);
      ctrl_forward = 1'b0; ctrl_reverse = 1'b1; step(12);
      ctrl_reverse = 1'b0; step(8);

      // illegal motor pair, fault_clr held off by set condition
      ctrl_forward = 1'b1; ctrl_reverse = 1'b1; step(3);
      fault_clr = 1'b1; step(1);
      fault_clr = 1'b0; step(2);
      ctrl_forward = 1'b0; ctrl_reverse = 1'b0; step(1);
      fault_clr = 1'b1; step(1);
      fault_clr = 1'b0; step(2);

      // fill with overflow cut-off
      ctrl_fill = 1'b1; step(6);
      level_full = 1'b1; step(3);
      ctrl_fill = 1'b0; level_full = 1'b0; step(2);

      // ena low while draining and running
      ctrl_release = 1'b1; ctrl_forward = 1'b1; step(8);
      ena = 1'b0; step(8);
      ena = 1'b1; ctrl_release = 1'b0; ctrl_forward = 1'b0; step(8);

      // single-cycle forward pulse (min on-time when enabled)
      ctrl_forward = 1'b1; step(1);
      ctrl_forward = 1'b0; step(10);
      ctrl_reverse = 1'b1; step(1);
      ctrl_reverse = 1'b0; step(10);

      // asynchronous reset mid-forward
      ctrl_forward = 1'b1; step(3);
      rst = 1'b1;
      check_reset("reset_mid_fwd");
      ctrl_forward = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset("reset_held");
      rst = 1'b0;
      model_reset();
      step(2);

      // randomized traffic with held requests
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 5) == 0) ctrl_forward = ~ctrl_forward;
         if ($urandom_range(0, 5) == 0) ctrl_reverse = ~ctrl_reverse;
         if ($urandom_range(0, 4) == 0) ctrl_fill    = ~ctrl_fill;
         if ($urandom_range(0, 4) == 0) ctrl_release = ~ctrl_release;
         if ($urandom_range(0, 6) == 0) level_full   = ~level_full;
         ena       = ($urandom_range(0, 19) != 0);
         fault_clr = ($urandom_range(0, 7) == 0);
         step(1);
      end
      ctrl_forward = 1'b0; ctrl_reverse = 1'b0; ctrl_fill = 1'b0;
      ctrl_release = 1'b0; fault_clr = 1'b0; ena = 1'b1;
      step(12);

      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/actuator_driver.md
# actuator_driver

Output stage of the washer controller: consumes the processor's `ctrl_fill`, `ctrl_release`, `ctrl_forward` and `ctrl_reverse` levels and drives the drum motor and the water valves. The block enforces the hardware interlocks the instruction stream cannot guarantee:
- a motor dead-time between directions,
- fill/drain mutual exclusion,
- overflow cut-off,
- a sticky fault flag for illegal request combinations.

All outputs are registered.

## Interface
Parameters:
- `DEADTIME`, default 200: cycles with both motor outputs low after any motor turn-off. Must be ≥1.
- `MIN_ON`, default 100: minimum motor on-time in cycles. Active only with `ACTUATOR_MIN_ON_EN`. Must be ≥1.
- `CNT_W`, default 16: width of the dead-time/on-time counter. Must hold max(`DEADTIME`, `MIN_ON`).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ena` in 1: when low, every request is treated as 0.
- `ctrl_fill` in 1: fill request from the processor.
- `ctrl_release` in 1: drain request from the processor.
- `ctrl_forward` in 1: forward-rotation request.
- `ctrl_reverse` in 1: reverse-rotation request.
- `level_full` in 1: tank-full sensor, already synchronised.
- `fault_clr` in 1: single-cycle pulse that clears `fault`.
- `motor_fwd` out 1: forward motor drive.
- `motor_rev` out 1: reverse motor drive.
- `valve_fill` out 1: inlet valve.
- `valve_drain` out 1: outlet valve.
- `busy` out 1: motor is not in `M_IDLE` (running or in dead-time).
- `fault` out 1: sticky illegal-request flag.

## Operation
- **Effective requests:** each `req_x` = `ctrl_x & ena`, sampled on the rising edge.
- **Motor FSM states:** `M_IDLE`, `M_FWD`, `M_REV`, `M_DEAD`.
  - `M_IDLE`: if `req_fwd & ~req_rev` go to `M_FWD`. If `req_rev & ~req_fwd` go to `M_REV`. If both are set, stay in `M_IDLE`.
  - `M_FWD`: if `req_fwd` drops, or `req_rev` rises, go to `M_DEAD` and load the counter with `DEADTIME-1`.
  - `M_REV`: same exit rule as `M_FWD` with the directions swapped.
  - `M_DEAD`: decrement the counter. When it reaches 0, go to `M_IDLE`. Requests are ignored while in `M_DEAD`.
  - A direct `M_FWD`↔`M_REV` transition is impossible.
- **Motor outputs:** `motor_fwd` = (state==`M_FWD`) and `motor_rev` = (state==`M_REV`), registered. The two are never high together.
- **Valves:**
  - `valve_fill` ← `req_fill & ~req_release & ~level_full`.
  - `valve_drain` ← `req_release & ~req_fill`.
  - Both are registered every cycle and the two are never high together.
- **Fault:**
  - Set when `req_fwd & req_rev`, or when `req_fill & req_release`, in any cycle.
  - Cleared by `fault_clr` only if no set condition is present in that cycle; a set condition wins.
  - `level_full` is not a fault.
- **`ena` low while running:** the motor goes to `M_DEAD` (normal dead-time applies) and both valves close the next cycle.

## Timing
- **Reset values:** all outputs are 0, the state is `M_IDLE` and the counter is 0.
- **Reset mid-operation:** reset de-energises the outputs immediately (asynchronously). Dead-time is not enforced across reset.
- **Latency:** a request at edge N produces an output change after edge N, i.e. 1 cycle, for both motor and valves.
- **Dead-time:** after the motor turns off, both motor outputs stay low for exactly `DEADTIME` cycles plus 1 idle-sampling cycle before either can assert again. With a continuous opposite request, the gap from off to the new direction is `DEADTIME+1` cycles.
- **`level_full`:** dropping the inlet takes 1 cycle from `level_full` high.
- **Simultaneous events:** an illegal pair and `fault_clr` in the same cycle leave `fault`=1.
- **Counter:** `CNT_W`-bit and saturates at 0 (no wrap).

## Configuration
- **`ACTUATOR_MIN_ON_EN` defined:**
  - Entering `M_FWD`/`M_REV` loads the counter with `MIN_ON-1`.
  - Exit to `M_DEAD` is deferred until the counter reaches 0, even if the request has dropped.
  - `ena` low still exits immediately.
- **Not defined:** no minimum on-time; exit follows the request on the next edge.

## Structure
- Shared package `washer_pkg`:
  - motor state enum (`M_IDLE`, `M_FWD`, `M_REV`, `M_DEAD`);
  - opcode localparams shared with the processor (`OP_WAIT`=0x01, `OP_FILL`=0x02, `OP_RELEASE`=0x03, `OP_FORWARD`=0x04, `OP_REVERSE`=0x05, `OP_SET`=0x11, `OP_DEC`=0x12, `OP_JZ`=0x21).
- One sub-module, `hold_timer`: loadable down-counter with a `zero` flag, used for both dead-time and min-on.

## Test plan
Bench parameters: `DEADTIME`=4, `MIN_ON`=3.
- **Reset:** assert `rst` mid-`M_FWD` → all outputs are 0 immediately and `busy`=0.
- **Direction change:** `ctrl_forward`=1 for 10 cycles, then `ctrl_reverse`=1 → `motor_fwd` high 1 cycle after the request, then both motor outputs low for 5 cycles, then `motor_rev`=1.
- **Illegal motor pair:** `ctrl_forward`=`ctrl_reverse`=1 from idle → motor stays off and `fault`=1. `fault_clr` with the requests still held → `fault` stays 1. Drop the requests, then pulse `fault_clr` → `fault`=0.
- **Fill with overflow:** `ctrl_fill`=1, then `level_full`=1 at cycle 6 → `valve_fill` drops at cycle 7 and `fault`=0.
- **`ena` low:** `ctrl_release` + `ctrl_forward` active, then `ena`=0 → `valve_drain`=0 after 1 cycle, and the motor enters `M_DEAD` with `busy`=1 for 4 cycles.
- **Min-on, `ACTUATOR_MIN_ON_EN` defined:** 1-cycle `ctrl_forward` pulse → `motor_fwd` high for 3 cycles. Without the macro → high for 1 cycle.
